// File: rtl/ctrl_mcast_demux.sv
// ctrl_mcast_demux: packet-level AXI-Stream demultiplexer with multicast.
// A selector taken on a packet's first beat picks one or more outputs.
// An empty destination mask drops the packet. Every accepted beat is
// written to all selected output FIFOs in the same cycle.
module ctrl_mcast_demux #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int D_COUNT    = 4,
  parameter int MODE       = 1,
  parameter int SEL_WIDTH  = MODE ? D_COUNT : $clog2(D_COUNT) + 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           s_val_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]           s_val_axis_tkeep,
  input  logic                            s_val_axis_tlast,
  input  logic                            s_val_axis_tvalid,
  output logic                            s_val_axis_tready,
  input  logic [SEL_WIDTH-1:0]            s_dispatcher_tdata,
  input  logic                            s_dispatcher_tvalid,
  output logic                            s_dispatcher_tready,
  output logic [D_COUNT*DATA_WIDTH-1:0]   m_val_axis_tdata,
  output logic [D_COUNT*KEEP_WIDTH-1:0]   m_val_axis_tkeep,
  output logic [D_COUNT-1:0]              m_val_axis_tlast,
  output logic [D_COUNT-1:0]              m_val_axis_tvalid,
  input  logic [D_COUNT-1:0]              m_val_axis_tready,
  output logic [31:0]                     drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]         state;
  logic [D_COUNT-1:0] cur_mask;
  logic [D_COUNT-1:0] dmask;
  logic [D_COUNT-1:0] fifo_full;
  logic [D_COUNT-1:0] wr_mask;
  logic               sel_fit;
  logic               cur_fit;
  logic               accept;

  // Destination mask decoded from the selector word
  if (MODE != 0) begin : g_mask_mode
    assign dmask = s_dispatcher_tdata[D_COUNT-1:0];
  end else begin : g_index_mode
    always_comb begin
      dmask = '0;
      for (int unsigned i = 0; i < D_COUNT; i++) begin
        if (s_dispatcher_tdata == SEL_WIDTH'(i)) dmask[i] = 1'b1;
      end
    end
  end

  assign sel_fit = ~|(dmask & fifo_full);
  assign cur_fit = ~|(cur_mask & fifo_full);

  // Handshakes and lockstep write enables; readys held low during reset
  always_comb begin
    s_val_axis_tready   = 1'b0;
    s_dispatcher_tready = 1'b0;
    wr_mask             = '0;
    if (rst) begin
      case (state)
        ST_IDLE: begin
          if (s_dispatcher_tvalid && sel_fit) begin
            s_val_axis_tready   = 1'b1;
            s_dispatcher_tready = s_val_axis_tvalid;
          end
        end
        ST_FWD:  s_val_axis_tready = cur_fit;
        ST_DROP: s_val_axis_tready = 1'b1;
        default: s_val_axis_tready = 1'b0;
      endcase
    end
    accept = s_val_axis_tvalid && s_val_axis_tready;
    if (accept) begin
      if (state == ST_IDLE)     wr_mask = dmask;
      else if (state == ST_FWD) wr_mask = cur_mask;
    end
  end

  // Packet FSM, latched destination mask and drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cur_mask   <= '0;
      drop_count <= '0;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          cur_mask <= dmask;
          if (dmask == '0) drop_count <= drop_count + 32'd1;
          if (!s_val_axis_tlast) state <= (dmask != '0) ? ST_FWD : ST_DROP;
        end
        ST_FWD, ST_DROP: begin
          if (s_val_axis_tlast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < D_COUNT; g++) begin : g_fifo
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign push         = wr_mask[g];
    assign pop          = m_val_axis_tvalid[g] && m_val_axis_tready[g];
    assign fifo_full[g] = (count == CW'(FIFO_DEPTH));
    assign head         = (count != '0) ? mem[rd_ptr] : '0;

    assign m_val_axis_tvalid[g]                            = (count != '0);
    assign m_val_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH]    = head[DATA_WIDTH-1:0];
    assign m_val_axis_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH]    = head[DATA_WIDTH +: KEEP_WIDTH];
    assign m_val_axis_tlast[g]                             = head[EW-1];

    // Storage write; fullness was already checked on the pre-read count
    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {s_val_axis_tlast, s_val_axis_tkeep, s_val_axis_tdata};
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ctrl_mcast_demux.sv
// Scoreboard bench for ctrl_mcast_demux: one index-mode instance (dut 0,
// depth 16) and one mask-mode instance (dut 1, depth 4).
module tb_ctrl_mcast_demux;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][63:0]  s_tdata;
  logic [1:0][7:0]   s_tkeep;
  logic [1:0]        s_tlast;
  logic [1:0]        s_tvalid;
  logic [1:0]        s_tready;
  logic [1:0][3:0]   d_sel;
  logic [1:0]        d_tvalid;
  logic [1:0]        d_tready;
  logic [1:0][255:0] m_tdata;
  logic [1:0][31:0]  m_tkeep;
  logic [1:0][3:0]   m_tlast;
  logic [1:0][3:0]   m_tvalid;
  logic [1:0][3:0]   m_tready;
  logic [1:0][31:0]  drop_cnt;

  ctrl_mcast_demux #(.DATA_WIDTH(64), .D_COUNT(4), .MODE(0), .FIFO_DEPTH(16)) u_idx (
    .clk(clk), .rst(rst),
    .s_val_axis_tdata(s_tdata[0]), .s_val_axis_tkeep(s_tkeep[0]),
    .s_val_axis_tlast(s_tlast[0]), .s_val_axis_tvalid(s_tvalid[0]),
    .s_val_axis_tready(s_tready[0]),
    .s_dispatcher_tdata(d_sel[0][2:0]), .s_dispatcher_tvalid(d_tvalid[0]),
    .s_dispatcher_tready(d_tready[0]),
    .m_val_axis_tdata(m_tdata[0]), .m_val_axis_tkeep(m_tkeep[0]),
    .m_val_axis_tlast(m_tlast[0]), .m_val_axis_tvalid(m_tvalid[0]),
    .m_val_axis_tready(m_tready[0]), .drop_count(drop_cnt[0])
  );

  ctrl_mcast_demux #(.DATA_WIDTH(64), .D_COUNT(4), .MODE(1), .FIFO_DEPTH(4)) u_msk (
    .clk(clk), .rst(rst),
    .s_val_axis_tdata(s_tdata[1]), .s_val_axis_tkeep(s_tkeep[1]),
    .s_val_axis_tlast(s_tlast[1]), .s_val_axis_tvalid(s_tvalid[1]),
    .s_val_axis_tready(s_tready[1]),
    .s_dispatcher_tdata(d_sel[1]), .s_dispatcher_tvalid(d_tvalid[1]),
    .s_dispatcher_tready(d_tready[1]),
    .m_val_axis_tdata(m_tdata[1]), .m_val_axis_tkeep(m_tkeep[1]),
    .m_val_axis_tlast(m_tlast[1]), .m_val_axis_tvalid(m_tvalid[1]),
    .m_val_axis_tready(m_tready[1]), .drop_count(drop_cnt[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pops [8];
  int sel_used [2];
  logic [72:0] exp_q [8][$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever an output handshake is pending
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (d_tvalid[d] && d_tready[d]) sel_used[d]++;
        for (int c = 0; c < 4; c++) begin
          if (m_tvalid[d][c] && m_tready[d][c]) begin
            logic [72:0] got, want;
            got = {m_tlast[d][c], m_tkeep[d][c*8 +: 8], m_tdata[d][c*64 +: 64]};
            checks++;
            pops[d*4+c]++;
            if (exp_q[d*4+c].size() == 0) begin
              errors++;
              $display("FAIL out_unexpected dut%0d ch%0d: got %h expected nothing", d, c, got);
            end else begin
              want = exp_q[d*4+c].pop_front();
              if (got !== want) begin
                errors++;
                $display("FAIL out_data dut%0d ch%0d: got %h expected %h", d, c, got, want);
              end
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic int qsum();
    int s = 0;
    for (int i = 0; i < 8; i++) s += exp_q[i].size();
    return s;
  endfunction

  // Present one beat and wait (bounded) for its acceptance; expected
  // entries are queued for every channel in the hand-computed mask.
  task automatic beat(input int d, input logic [63:0] data, input logic last,
                      input logic [3:0] sel, input logic [3:0] emask, output int waited);
    bit ok = 0;
    waited = 0;
    s_tdata[d] = data; s_tkeep[d] = ~data[7:0]; s_tlast[d] = last;
    s_tvalid[d] = 1'b1; d_tvalid[d] = 1'b1; d_sel[d] = sel;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (s_tready[d]) begin
        ok = 1;
        for (int c = 0; c < 4; c++)
          if (emask[c]) exp_q[d*4+c].push_back({last, ~data[7:0], data});
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    s_tvalid[d] = 1'b0; d_tvalid[d] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: beat %0h never accepted", d, data);
    end
  endtask

  task automatic pkt(input int d, input logic [3:0] sel, input logic [3:0] emask,
                     input int n, input logic [63:0] base);
    int w;
    for (int b = 0; b < n; b++) beat(d, base + 64'(b), (b == n - 1), sel, emask, w);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, t0, u0, p0, p1;
    bit stalled_ok;
    s_tdata = '0; s_tkeep = '0; s_tlast = '0; d_sel = '0;
    m_tready = '1;
    for (int i = 0; i < 8; i++) pops[i] = 0;
    sel_used[0] = 0; sel_used[1] = 0;
    // Inputs asserted during reset: readys must still be low
    s_tvalid = 2'b11; d_tvalid = 2'b11;
    settle(3);
    chk("rst_tvalid_idx", 64'(m_tvalid[0]), 64'h0);
    chk("rst_tvalid_msk", 64'(m_tvalid[1]), 64'h0);
    chk("rst_s_tready", 64'(s_tready), 64'h0);
    chk("rst_d_tready", 64'(d_tready), 64'h0);
    chk("rst_drop_idx", 64'(drop_cnt[0]), 64'h0);
    chk("rst_tdata_msk", m_tdata[1][63:0], 64'h0);
    s_tvalid = '0; d_tvalid = '0;
    rst = 1'b1;
    settle(2);

    // Unicast, index mode: sel=2
    u0 = sel_used[0];
    beat(0, 64'hA0, 1'b0, 4'd2, 4'b0100, w);
    chk("uni_latency_valid", 64'(m_tvalid[0]), 64'h4);
    beat(0, 64'hA1, 1'b0, 4'd2, 4'b0100, w);
    beat(0, 64'hA2, 1'b1, 4'd2, 4'b0100, w);
    settle(4);
    chk("uni_sel_consumed", 64'(sel_used[0] - u0), 64'd1);
    chk("uni_ch2_beats", 64'(pops[2]), 64'd3);

    // Multicast, mask mode: 1011
    u0 = sel_used[1];
    pkt(1, 4'b1011, 4'b1011, 2, 64'hB0);
    settle(4);
    chk("mc_sel_consumed", 64'(sel_used[1] - u0), 64'd1);
    chk("mc_ch2_idle", 64'(pops[6]), 64'd0);
    chk("mc_ch3_beats", 64'(pops[7]), 64'd2);

    // Drop: empty mask (mask dut), out-of-range index (index dut)
    chk("drop_msk_before", 64'(drop_cnt[1]), 64'd0);
    beat(1, 64'h10, 1'b0, 4'b0000, 4'b0000, w);
    chk("drop_msk_first_wait", 64'(w), 64'd0);
    chk("drop_msk_after_first", 64'(drop_cnt[1]), 64'd1);
    for (int b = 1; b < 4; b++) begin
      beat(1, 64'h10 + 64'(b), (b == 3), 4'b0000, 4'b0000, w);
      chk("drop_msk_ready", 64'(w), 64'd0);
    end
    chk("drop_msk_total", 64'(drop_cnt[1]), 64'd1);
    pkt(0, 4'd6, 4'b0000, 2, 64'h20);
    chk("drop_idx_total", 64'(drop_cnt[0]), 64'd1);
    pkt(1, 4'b0000, 4'b0000, 1, 64'h30);
    chk("drop_msk_second", 64'(drop_cnt[1]), 64'd2);
    settle(3);

    // Back-to-back single-beat packets, index mode
    u0 = sel_used[0];
    t0 = cyc;
    beat(0, 64'hC0, 1'b1, 4'd0, 4'b0001, w);
    beat(0, 64'hC1, 1'b1, 4'd1, 4'b0010, w);
    beat(0, 64'hC2, 1'b1, 4'd2, 4'b0100, w);
    chk("b2b_cycles", 64'(cyc - t0), 64'd3);
    settle(3);
    chk("b2b_sel_consumed", 64'(sel_used[0] - u0), 64'd3);

    // Backpressure: depth-4 mask dut, channel 1 stalled
    m_tready[1] = 4'b1101;
    p0 = pops[4]; p1 = pops[5];
    for (int b = 0; b < 4; b++) beat(1, 64'hD0 + 64'(b), 1'b0, 4'b0011, 4'b0011, w);
    s_tdata[1] = 64'hD4; s_tkeep[1] = ~8'hD4; s_tlast[1] = 1'b0;
    s_tvalid[1] = 1'b1; d_tvalid[1] = 1'b1;
    stalled_ok = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (s_tready[1]) stalled_ok = 0;
      @(posedge clk); #1;
    end
    chk("bp_stalled", 64'(stalled_ok), 64'd1);
    chk("bp_ch0_holds4", 64'(pops[4] - p0), 64'd4);
    chk("bp_ch1_none", 64'(pops[5] - p1), 64'd0);
    m_tready[1] = 4'b1111;
    beat(1, 64'hD4, 1'b0, 4'b0011, 4'b0011, w);
    beat(1, 64'hD5, 1'b1, 4'b0011, 4'b0011, w);
    settle(8);
    chk("bp_ch0_all6", 64'(pops[4] - p0), 64'd6);
    chk("bp_ch1_all6", 64'(pops[5] - p1), 64'd6);
    chk("bp_queues_empty", 64'(qsum()), 64'd0);

    // Async reset mid-packet with data held in a FIFO
    m_tready[1] = 4'b0000;
    beat(1, 64'hE0, 1'b0, 4'b0001, 4'b0001, w);
    beat(1, 64'hE1, 1'b0, 4'b0001, 4'b0001, w);
    chk("ar_fifo_holds", 64'(m_tvalid[1]), 64'h1);
    s_tdata[1] = 64'hE2; s_tkeep[1] = ~8'hE2; s_tlast[1] = 1'b1;
    s_tvalid[1] = 1'b1; d_tvalid[1] = 1'b1; d_sel[1] = 4'b0001;
    #2 rst = 1'b0;
    #1;
    chk("ar_tvalid_msk", 64'(m_tvalid[1]), 64'h0);
    chk("ar_tvalid_idx", 64'(m_tvalid[0]), 64'h0);
    chk("ar_s_tready", 64'(s_tready[1]), 64'h0);
    chk("ar_d_tready", 64'(d_tready[1]), 64'h0);
    for (int i = 0; i < 8; i++) exp_q[i].delete();
    s_tvalid[1] = 1'b0; d_tvalid[1] = 1'b0;
    m_tready[1] = 4'b1111;
    settle(2);
    rst = 1'b1;
    settle(1);
    chk("ar_post_tvalid", 64'(m_tvalid[1]), 64'h0);
    chk("ar_post_drop_msk", 64'(drop_cnt[1]), 64'd0);
    chk("ar_post_drop_idx", 64'(drop_cnt[0]), 64'd0);
    // Remainder of the packet must wait for a fresh selector
    s_tvalid[1] = 1'b1; d_tvalid[1] = 1'b0;
    @(negedge clk);
    chk("ar_idle_needs_sel", 64'(s_tready[1]), 64'h0);
    @(posedge clk); #1;
    p0 = pops[4];
    beat(1, 64'hE2, 1'b1, 4'b0001, 4'b0001, w);
    settle(4);
    chk("ar_remainder_out", 64'(pops[4] - p0), 64'd1);

    settle(5);
    chk("final_queues_empty", 64'(qsum()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
